// File: rtl/smvm_pkg.sv
// smvm_pkg: shared definitions for the SMVM stream sequencer.
//   K          nonzeros per ALU group (default job granularity)
//   MAX_SHAPE  largest supported row/column count
//   VAL_W      value field width
//   COL_W      column index field width
//   nz_word_t  packed nonzero memory entry {ipv, col, val}
//   seq_state_t sequencer FSM states
package smvm_pkg;

  localparam int K         = 4;
  localparam int MAX_SHAPE = 256;
  localparam int VAL_W     = 8;
  localparam int COL_W     = 9;

  typedef struct packed {
    logic             ipv;
    logic [COL_W-1:0] col;
    logic [VAL_W-1:0] val;
  } nz_word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HROWS,
    S_HCOLS,
    S_VEC,
    S_NZV,
    S_NZI,
    S_TERM,
    S_DRAIN
  } seq_state_t;

endpackage

// File: rtl/smvm_drain_mon.sv
// smvm_drain_mon: result-side bookkeeping for one sequencer job.
// Optional feature macro: SMVM_SEQ_TIMEOUT_EN (enables the no-result timeout).
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clear      accepted start; zeroes all counters
//   arm        high from stream termination until the job finishes
//   r_valid    SMVM out_valid
//   rows       row count of the running job
//   r_count    results received, saturating at 511
//   complete   all rows received and the settle gap has elapsed
//   timeout    TO_CYC consecutive armed cycles without a result
module smvm_drain_mon #(
  parameter int GAP    = 8,
  parameter int TO_CYC = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       arm,
  input  logic       r_valid,
  input  logic [8:0] rows,
  output logic [8:0] r_count,
  output logic       complete,
  output logic       timeout
);

  // Extra headroom keeps the counter at least one bit wide even for GAP=0.
  localparam int GAP_W = $clog2(GAP + 2);

  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (arm && r_valid && (r_count != 9'd511)) begin
      r_count <= r_count + 9'd1;
    end
  end

  // Starts counting in the termination cycle, so it equals the number of
  // cycles elapsed since termination until it parks at GAP.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      gap_cnt <= '0;
    end else if (arm && (gap_cnt != GAP_W'(GAP))) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  assign complete = (gap_cnt == GAP_W'(GAP)) && (r_count >= rows);

`ifdef SMVM_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);

  logic [TO_W-1:0] idle_cnt;

  // idle_cnt holds the number of earlier result-free cycles; the current
  // cycle is the TO_CYC-th one when it reaches TO_CYC-1 with no r_valid.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idle_cnt <= '0;
    end else if (arm) begin
      if (r_valid) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TO_W'(TO_CYC - 1)) begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end
    end
  end

  assign timeout = arm && !r_valid && (idle_cnt == TO_W'(TO_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/smvm_seq.sv
// smvm_seq: stream sequencer feeding the SMVM core from vector and nonzero
// memories, then waiting for all row results.
// Optional feature macro: SMVM_SEQ_TIMEOUT_EN (drain timeout with err=1).
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, rows, cols, nnz   job request and its shape
//   busy, done, err     job status; err qualifies done
//   vec_rd/addr/rdata   vector memory, one-cycle read latency
//   nz_rd/addr/rdata    nonzero memory {ipv, col, val}, one-cycle latency
//   s_valid/s_val/s_ipv SMVM input stream
//   r_valid, r_count    SMVM result strobe and received-result count
module smvm_seq
  import smvm_pkg::*;
#(
  parameter int K      = smvm_pkg::K,
  parameter int ADDR_W = 10,
  parameter int GAP    = 8,
  parameter int TO_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        rows,
  input  logic [8:0]        cols,
  input  logic [ADDR_W:0]   nnz,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              vec_rd,
  output logic [7:0]        vec_addr,
  input  logic [7:0]        vec_rdata,
  output logic              nz_rd,
  output logic [ADDR_W-1:0] nz_addr,
  input  logic [17:0]       nz_rdata,
  output logic              s_valid,
  output logic [7:0]        s_val,
  output logic              s_ipv,
  input  logic              r_valid,
  output logic [8:0]        r_count
);

  seq_state_t        state, state_d;
  logic [8:0]        rows_q, cols_q;
  logic [ADDR_W:0]   nnz_q;
  logic [8:0]        idx, idx_d;
  logic [ADDR_W-1:0] ent, ent_d;
  nz_word_t          nz_in, nz_q;
  logic              rej_q;
  logic              accept, reject, bad_job, arm;
  logic              complete, timeout;

  assign nz_in = nz_word_t'(nz_rdata);

  assign bad_job = (cols == 9'd0) || (cols > 9'(MAX_SHAPE)) || (nnz == '0) ||
                   ((nnz % (ADDR_W+1)'(K)) != '0);

  assign busy = (state != S_IDLE);

  // State and job registers; the job shape is latched so the stream does not
  // depend on the host holding its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      rows_q <= '0;
      cols_q <= '0;
      nnz_q  <= '0;
      idx    <= '0;
      ent    <= '0;
      nz_q   <= '0;
      rej_q  <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      ent   <= ent_d;
      rej_q <= reject;
      if (accept) begin
        rows_q <= rows;
        cols_q <= cols;
        nnz_q  <= nnz;
      end
      if (state == S_NZV) begin
        nz_q <= nz_in;
      end
    end
  end

  // Next state and all stream/memory outputs. Every read is issued in the
  // cycle before its word is emitted so the stream stays gapless.
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    ent_d    = ent;
    accept   = 1'b0;
    reject   = 1'b0;
    arm      = 1'b0;
    vec_rd   = 1'b0;
    vec_addr = '0;
    nz_rd    = 1'b0;
    nz_addr  = '0;
    s_valid  = 1'b0;
    s_val    = '0;
    s_ipv    = 1'b0;
    done     = rej_q;
    err      = rej_q;
    case (state)
      S_IDLE: begin
        // The reject pulse cycle still counts as part of that job.
        if (start && !rej_q) begin
          if (bad_job) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_HROWS;
          end
        end
      end
      S_HROWS: begin
        s_valid          = 1'b1;
        {s_val, s_ipv}   = rows_q;
        state_d          = S_HCOLS;
      end
      S_HCOLS: begin
        s_valid          = 1'b1;
        {s_val, s_ipv}   = cols_q;
        vec_rd           = 1'b1;
        idx_d            = '0;
        state_d          = S_VEC;
      end
      S_VEC: begin
        s_valid = 1'b1;
        s_val   = vec_rdata;
        if (idx == cols_q - 9'd1) begin
          nz_rd   = 1'b1;
          ent_d   = '0;
          state_d = S_NZV;
        end else begin
          vec_rd   = 1'b1;
          vec_addr = idx[7:0] + 8'd1;
          idx_d    = idx + 9'd1;
        end
      end
      S_NZV: begin
        s_valid = 1'b1;
        s_val   = nz_in.val;
        s_ipv   = nz_in.ipv;
        state_d = S_NZI;
      end
      S_NZI: begin
        s_valid        = 1'b1;
        {s_val, s_ipv} = nz_q.col;
        if ({1'b0, ent} == nnz_q - (ADDR_W+1)'(1)) begin
          state_d = S_TERM;
        end else begin
          nz_rd   = 1'b1;
          nz_addr = ent + ADDR_W'(1);
          ent_d   = ent + ADDR_W'(1);
          state_d = S_NZV;
        end
      end
      S_TERM: begin
        arm     = 1'b1;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        arm = 1'b1;
        // A full result set wins over a coincident timeout.
        if (complete || timeout) begin
          done    = 1'b1;
          err     = !complete;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  smvm_drain_mon #(
    .GAP    (GAP),
    .TO_CYC (TO_CYC)
  ) u_drain_mon (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .arm      (arm),
    .r_valid  (r_valid),
    .rows     (rows_q),
    .r_count  (r_count),
    .complete (complete),
    .timeout  (timeout)
  );

endmodule

// File: tb/tb_smvm_seq.sv
// tb_smvm_seq: self-checking bench for smvm_seq.
// Expected streams are built from the job description and memory contents;
// done timing is derived from the result schedule, GAP and TO_CYC.
module tb_smvm_seq;
  import smvm_pkg::*;

  localparam int ADDR_W = 10;
  localparam int GAP    = 8;
  localparam int TO_CYC = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [8:0]        rows, cols;
  logic [ADDR_W:0]   nnz;
  logic              busy, done, err;
  logic              vec_rd, nz_rd;
  logic [7:0]        vec_addr;
  logic [7:0]        vec_rdata = '0;
  logic [ADDR_W-1:0] nz_addr;
  logic [17:0]       nz_rdata = '0;
  logic              s_valid, s_ipv;
  logic [7:0]        s_val;
  logic              r_valid;
  logic [8:0]        r_count;

  logic [7:0]  vec_mem [256];
  logic [17:0] nz_mem  [1 << ADDR_W];
  logic [8:0]  exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int model_rcount = 0;

  typedef struct {
    int rows;
    int cols;
    int nnz;
    bit rej;
  } job_vec_t;

  job_vec_t tbl [9];

  smvm_seq #(.K(4), .ADDR_W(ADDR_W), .GAP(GAP), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols), .nnz(nnz),
    .busy(busy), .done(done), .err(err),
    .vec_rd(vec_rd), .vec_addr(vec_addr), .vec_rdata(vec_rdata),
    .nz_rd(nz_rd), .nz_addr(nz_addr), .nz_rdata(nz_rdata),
    .s_valid(s_valid), .s_val(s_val), .s_ipv(s_ipv),
    .r_valid(r_valid), .r_count(r_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk) begin
    if (vec_rd) vec_rdata <= vec_mem[vec_addr];
    if (nz_rd)  nz_rdata  <= nz_mem[nz_addr];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Issue a start in the next cycle; also checks the idle state left by the
  // previous job (no done, not busy, result count held).
  task automatic applyStimulus(input int r, input int c, input int n);
    @(negedge clk);
    start = 1'b1;
    rows  = 9'(r);
    cols  = 9'(c);
    nnz   = (ADDR_W+1)'(n);
    #1;
    checkOutput("idle_before_start", {done, busy, r_count}, {1'b0, 1'b0, 9'(model_rcount)});
  endtask

  task automatic fill_random(input int c, input int n);
    for (int i = 0; i < c; i++) vec_mem[i] = 8'($urandom);
    for (int j = 0; j < n; j++) nz_mem[j] = 18'($urandom);
  endtask

  // Reference stream: header words, vector words, then val/col pairs.
  task automatic build_stream(input int r, input int c, input int n);
    nz_word_t e;
    exp_q.delete();
    exp_q.push_back(9'(r));
    exp_q.push_back(9'(c));
    for (int i = 0; i < c; i++) exp_q.push_back({vec_mem[i], 1'b0});
    for (int j = 0; j < n; j++) begin
      e = nz_word_t'(nz_mem[j]);
      exp_q.push_back({e.val, e.ipv});
      exp_q.push_back(e.col);
    end
  endtask

  task automatic run_stream(input int r, input int c, input int n, input bit restart);
    build_stream(r, c, n);
    applyStimulus(r, c, n);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      start = restart && (k == 2);
      #1;
      checkOutput($sformatf("stream[%0d]", k), {done, s_valid, s_val, s_ipv},
                  {1'b0, 1'b1, exp_q[k]});
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("term", {s_valid, busy, done}, 3'b010);
  endtask

  // Returns n_res results at random spacing after termination and checks
  // when and how the job finishes.
  task automatic run_drain(input int r, input int n_res);
    int sched [$];
    int t;
    int exp_off;
    int got_off;
    int limit;
    bit exp_err;
    t = 0;
    for (int i = 0; i < n_res; i++) begin
      t += $urandom_range(1, 3);
      sched.push_back(t);
    end
    exp_err = 1'b0;
    if (n_res >= r) begin
      exp_off = GAP;
      if (r > 0 && sched[r-1] + 1 > exp_off) exp_off = sched[r-1] + 1;
    end else begin
`ifdef SMVM_SEQ_TIMEOUT_EN
      exp_err = 1'b1;
      exp_off = sched[n_res-1] + TO_CYC;
`else
      exp_off = -1;
`endif
    end
    limit   = (exp_off < 0) ? 60 : exp_off + 50;
    got_off = -1;
    for (int off = 1; off <= limit; off++) begin
      @(negedge clk);
      r_valid = 1'b0;
      foreach (sched[i]) if (sched[i] == off) r_valid = 1'b1;
      #1;
      if (done) begin
        got_off = off;
        break;
      end
    end
    r_valid = 1'b0;
    if (exp_off < 0) begin
      checkOutput("no_done_without_results", 64'(got_off), 64'(-1));
      checkOutput("still_busy", {63'd0, busy}, 64'd1);
    end else if (got_off < 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL done_wait: no done within %0d cycles, required at offset %0d", limit, exp_off);
    end else begin
      checkOutput("done_offset", 64'(got_off), 64'(exp_off));
      checkOutput("done_err_busy", {err, busy}, {exp_err, 1'b1});
      checkOutput("r_count_at_done", r_count, 9'(n_res));
    end
    model_rcount = n_res;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_rcount = 0;
  endtask

  initial begin
    int r, c, n;
    rst = 1'b1; start = 1'b0; r_valid = 1'b0;
    rows = '0; cols = '0; nnz = '0;

    tbl[0] = '{rows: 4, cols: 3,   nnz: 6,  rej: 1'b1};
    tbl[1] = '{rows: 1, cols: 0,   nnz: 4,  rej: 1'b1};
    tbl[2] = '{rows: 1, cols: 257, nnz: 4,  rej: 1'b1};
    tbl[3] = '{rows: 1, cols: 3,   nnz: 0,  rej: 1'b1};
    tbl[4] = '{rows: 2, cols: 5,   nnz: 4,  rej: 1'b0};
    tbl[5] = '{rows: 5, cols: 1,   nnz: 8,  rej: 1'b0};
    tbl[6] = '{rows: 0, cols: 2,   nnz: 4,  rej: 1'b0};
    tbl[7] = '{rows: 3, cols: 256, nnz: 12, rej: 1'b0};
    tbl[8] = '{rows: 1, cols: 4,   nnz: 3,  rej: 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_outputs",
                {busy, done, err, vec_rd, nz_rd, s_valid, s_val, s_ipv, vec_addr, nz_addr, r_count}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Reference job: vec {5,6,7}, entries (2,c1,0) (3,c2,1) (1,c0,0) (4,c1,1)
    vec_mem[0] = 8'd5; vec_mem[1] = 8'd6; vec_mem[2] = 8'd7;
    nz_mem[0] = {1'b0, 9'd1, 8'd2};
    nz_mem[1] = {1'b1, 9'd2, 8'd3};
    nz_mem[2] = {1'b0, 9'd0, 8'd1};
    nz_mem[3] = {1'b1, 9'd1, 8'd4};
    run_stream(4, 3, 4, 1'b0);
    run_drain(4, 4);

    // Table of accepted and rejected shapes
    foreach (tbl[v]) begin
      if (tbl[v].rej) begin
        applyStimulus(tbl[v].rows, tbl[v].cols, tbl[v].nnz);
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput($sformatf("reject[%0d]", v), {done, err, busy, s_valid, r_count},
                    {4'b1100, 9'(model_rcount)});
      end else begin
        fill_random(tbl[v].cols, tbl[v].nnz);
        run_stream(tbl[v].rows, tbl[v].cols, tbl[v].nnz, 1'b0);
        run_drain(tbl[v].rows, tbl[v].rows);
      end
    end

    // Second start pulsed during VEC must be ignored
    fill_random(4, 4);
    run_stream(3, 4, 4, 1'b1);
    run_drain(3, 3);

    // Reset during the second NZI, then a clean job two cycles later
    fill_random(3, 4);
    build_stream(2, 3, 4);
    applyStimulus(2, 3, 4);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      checkOutput($sformatf("pre_rst_stream[%0d]", k), {s_valid, s_val, s_ipv}, {1'b1, exp_q[k]});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_job_outputs",
                {busy, done, err, vec_rd, nz_rd, s_valid, s_val, s_ipv, vec_addr, nz_addr, r_count}, '0);
    model_rcount = 0;
    @(negedge clk);
    fill_random(3, 4);
    run_stream(2, 3, 4, 1'b0);
    run_drain(2, 2);

    // Randomised jobs
    for (int it = 0; it < 4; it++) begin
      r = $urandom_range(0, 8);
      c = $urandom_range(1, 20);
      n = 4 * $urandom_range(1, 4);
      fill_random(c, n);
      run_stream(r, c, n, 1'b0);
      run_drain(r, r);
    end

    // Only half the results come back
    fill_random(2, 4);
    run_stream(4, 2, 4, 1'b0);
    run_drain(4, 2);
    pulse_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
